// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and helpers for the MIPS hazard unit: forwarding selects,
// divider FSM states and the $0-aware register compare.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  localparam logic [1:0] DIV_IDLE = 2'b00;
  localparam logic [1:0] DIV_BUSY = 2'b01;
  localparam logic [1:0] DIV_DONE = 2'b10;

  typedef logic [4:0] reg_addr_t;

  // $0 is hardwired to zero, so it never creates a dependency.
  function automatic logic reg_hit(input reg_addr_t a, input reg_addr_t b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard unit <-> datapath bundle. With HAZARD_PERF_CNT_EN defined the bundle
// also carries the 32-bit stall_cnt performance counter.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  reg_addr_t  rsD, rtD, rsE, rtE;
  reg_addr_t  writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW;
  logic       memtoRegE, memtoRegM;
  logic       branchD, jrD, div_startE;
  logic       forwardAD, forwardBD;
  logic [1:0] forwardAE, forwardBE;
  logic       stallF, stallD, stallE, flushE, flushM;
  logic       div_busy, div_doneE;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    output regwriteE, regwriteM, regwriteW, memtoRegE, memtoRegM,
    output branchD, jrD, div_startE,
    input  forwardAD, forwardBD, forwardAE, forwardBE,
    input  stallF, stallD, stallE, flushE, flushM, div_busy, div_doneE
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    input  regwriteE, regwriteM, regwriteW, memtoRegE, memtoRegM,
    input  branchD, jrD, div_startE,
    output forwardAD, forwardBD, forwardAE, forwardBE,
    output stallF, stallD, stallE, flushE, flushM, div_busy, div_doneE
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cnt
`endif
  );

endinterface

// File: rtl/hazard_ctrl_div_stall_fsm.sv
// Stall sequencer for the multi-cycle DIV/DIVU unit: the start cycle plus
// DIV_CYCLES-1 BUSY cycles stall, then a one-cycle DONE pulse.
module div_stall_fsm
  import hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic hold,
  output logic busy,
  output logic stall,
  output logic done
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // BUSY leaves once the decrement lands on zero, giving DIV_CYCLES-1 BUSY cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DIV_IDLE: if (start && !hold) begin
        state_d = DIV_BUSY;
        cnt_d   = CNT_LOAD;
      end
      DIV_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_LAST) state_d = DIV_DONE;
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy  = (state_q != DIV_IDLE);
  assign done  = (state_q == DIV_DONE);
  // Reset releases the pipeline in the same cycle it is seen.
  assign stall = !rst && ((state_q == DIV_BUSY) || ((state_q == DIV_IDLE) && start));

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage MIPS pipeline: forwarding, load/branch stalls,
// divider stalls. Optional stall counter under HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  logic [1:0] fwd_ae, fwd_be;
  logic       lwstall, brstall, divstall, dep_e, dep_m;

  // M-stage result is newer than W-stage, so it wins.
  always_comb begin
    fwd_ae = FWD_REG;
    if (hz.regwriteM && reg_hit(hz.writeregM, hz.rsE))      fwd_ae = FWD_M;
    else if (hz.regwriteW && reg_hit(hz.writeregW, hz.rsE)) fwd_ae = FWD_W;
    fwd_be = FWD_REG;
    if (hz.regwriteM && reg_hit(hz.writeregM, hz.rtE))      fwd_be = FWD_M;
    else if (hz.regwriteW && reg_hit(hz.writeregW, hz.rtE)) fwd_be = FWD_W;
  end

  assign hz.forwardAE = fwd_ae;
  assign hz.forwardBE = fwd_be;
  assign hz.forwardAD = hz.regwriteM && reg_hit(hz.writeregM, hz.rsD);
  assign hz.forwardBD = hz.regwriteM && reg_hit(hz.writeregM, hz.rtD);

  assign lwstall = hz.memtoRegE && (reg_hit(hz.rtE, hz.rsD) || reg_hit(hz.rtE, hz.rtD));
  assign dep_e   = hz.regwriteE && (reg_hit(hz.writeregE, hz.rsD) || reg_hit(hz.writeregE, hz.rtD));
  assign dep_m   = hz.memtoRegM && (reg_hit(hz.writeregM, hz.rsD) || reg_hit(hz.writeregM, hz.rtD));
  assign brstall = (hz.branchD || hz.jrD) && (dep_e || dep_m);

  div_stall_fsm #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (hz.div_startE),
    .hold  (lwstall || brstall),
    .busy  (hz.div_busy),
    .stall (divstall),
    .done  (hz.div_doneE)
  );

  assign hz.stallF = lwstall || brstall || divstall;
  assign hz.stallD = lwstall || brstall || divstall;
  assign hz.stallE = divstall;
  assign hz.flushM = divstall;
  assign hz.flushE = (lwstall || brstall) && !divstall;

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hz.stallF) stall_cnt_d = sat_inc(stall_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign hz.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected outputs are queued as each
// cycle's stimulus is driven and popped when the DUT outputs are sampled.
module tb_hazard_ctrl;
  localparam int DIV_CYCLES = 32;

  typedef struct packed {
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
    logic       rwE, rwM, rwW, mtrE, mtrM, br, jr, ds;
  } stim_t;

  typedef struct packed {
    logic [1:0]  fAE, fBE;
    logic        fAD, fBD, sF, sD, sE, fE, fM, busy, done;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  hazard_ctrl_if hif();

  hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif)
  );

  always #5 clk = ~clk;

  int    n_chk = 0;
  int    n_bad = 0;
  exp_t  exp_q[$];
  stim_t s;

  // Reference state for the divider and stall counter.
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_cnt  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  task automatic cyc(input stim_t st);
    exp_t e, w, g;
    bit   lw, bs, ds_stall, idle;
    @(negedge clk);
    rst            = st.rst;
    hif.rsD        = st.rsD;  hif.rtD = st.rtD;
    hif.rsE        = st.rsE;  hif.rtE = st.rtE;
    hif.writeregE  = st.wE;   hif.writeregM = st.wM; hif.writeregW = st.wW;
    hif.regwriteE  = st.rwE;  hif.regwriteM = st.rwM; hif.regwriteW = st.rwW;
    hif.memtoRegE  = st.mtrE; hif.memtoRegM = st.mtrM;
    hif.branchD    = st.br;   hif.jrD = st.jr;
    hif.div_startE = st.ds;

    e = '0;
    if (st.rwM && hit(st.wM, st.rsE))      e.fAE = 2'b10;
    else if (st.rwW && hit(st.wW, st.rsE)) e.fAE = 2'b01;
    if (st.rwM && hit(st.wM, st.rtE))      e.fBE = 2'b10;
    else if (st.rwW && hit(st.wW, st.rtE)) e.fBE = 2'b01;
    e.fAD = st.rwM && hit(st.wM, st.rsD);
    e.fBD = st.rwM && hit(st.wM, st.rtD);
    lw    = st.mtrE && (hit(st.rtE, st.rsD) || hit(st.rtE, st.rtD));
    bs    = (st.br || st.jr) &&
            ((st.rwE && (hit(st.wE, st.rsD) || hit(st.wE, st.rtD))) ||
             (st.mtrM && (hit(st.wM, st.rsD) || hit(st.wM, st.rtD))));
    idle     = (m_left == 0) && !m_done;
    ds_stall = !st.rst && ((m_left > 0) || (idle && st.ds));
    e.sF   = lw || bs || ds_stall;
    e.sD   = e.sF;
    e.sE   = ds_stall;
    e.fM   = ds_stall;
    e.fE   = (lw || bs) && !ds_stall;
    e.busy = !idle;
    e.done = m_done;
    e.cnt  = m_cnt;
    exp_q.push_back(e);

    #2;
    w = exp_q.pop_front();
    g = '0;
    g.fAE = hif.forwardAE; g.fBE = hif.forwardBE;
    g.fAD = hif.forwardAD; g.fBD = hif.forwardBD;
    g.sF = hif.stallF; g.sD = hif.stallD; g.sE = hif.stallE;
    g.fE = hif.flushE; g.fM = hif.flushM;
    g.busy = hif.div_busy; g.done = hif.div_doneE;
    chk("forwardAE", 32'(g.fAE), 32'(w.fAE));
    chk("forwardBE", 32'(g.fBE), 32'(w.fBE));
    chk("forwardAD", 32'(g.fAD), 32'(w.fAD));
    chk("forwardBD", 32'(g.fBD), 32'(w.fBD));
    chk("stallF",    32'(g.sF),  32'(w.sF));
    chk("stallD",    32'(g.sD),  32'(w.sD));
    chk("stallE",    32'(g.sE),  32'(w.sE));
    chk("flushE",    32'(g.fE),  32'(w.fE));
    chk("flushM",    32'(g.fM),  32'(w.fM));
    chk("div_busy",  32'(g.busy), 32'(w.busy));
    chk("div_doneE", 32'(g.done), 32'(w.done));
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt", hif.stall_cnt, w.cnt);
`endif

    if (st.rst) begin
      m_left = 0; m_done = 1'b0; m_cnt = '0;
    end else begin
      if (e.sF && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (m_done) m_done = 1'b0;
      else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end else if (st.ds && !(lw || bs)) m_left = DIV_CYCLES - 1;
    end
  endtask

  task automatic div_run(input int n);
    for (int i = 0; i < n; i++) cyc(s);
  endtask

  initial begin
    s = '0;
    s.rst = 1'b1;
    cyc(s); cyc(s);
    s.rst = 1'b0;
    cyc(s);

    // Forwarding into E: M match, W-only match, $0 never matches.
    s = '0; s.rwM = 1'b1; s.wM = 5'd8; s.rsE = 5'd8; cyc(s);
    s = '0; s.rwW = 1'b1; s.wW = 5'd8; s.rsE = 5'd8; s.rtE = 5'd8; cyc(s);
    s = '0; s.rwM = 1'b1; s.rwW = 1'b1; s.wM = 5'd3; s.wW = 5'd3; s.rtE = 5'd3; cyc(s);
    s = '0; s.rwM = 1'b1; s.wM = 5'd0; s.rsE = 5'd0; s.rsD = 5'd0; cyc(s);

    // Load-use: one stall cycle, then the load has moved on.
    s = '0; s.mtrE = 1'b1; s.rtE = 5'd9; s.rsD = 5'd9; cyc(s);
    s = '0; s.mtrM = 1'b1; s.wM = 5'd9; s.rsD = 5'd9; cyc(s);

    // Branch chain on $10: ALU producer in E, load in M, then forward.
    s = '0; s.br = 1'b1; s.rsD = 5'd10; s.rwE = 1'b1; s.wE = 5'd10; cyc(s);
    s = '0; s.br = 1'b1; s.rsD = 5'd10; s.mtrM = 1'b1; s.rwM = 1'b1; s.wM = 5'd10; cyc(s);
    s = '0; s.br = 1'b1; s.rsD = 5'd10; s.rwM = 1'b1; s.wM = 5'd10; cyc(s);
    s = '0; s.jr = 1'b1; s.rtD = 5'd11; s.rwE = 1'b1; s.wE = 5'd11; cyc(s);

    // Full divide: start + 31 BUSY + DONE, then idle.
    s = '0; s.ds = 1'b1;
    div_run(DIV_CYCLES + 1);
    s.ds = 1'b0;
    cyc(s); cyc(s);

    // Divide start blocked by a branch hazard, then released.
    s = '0; s.ds = 1'b1; s.br = 1'b1; s.rsD = 5'd4; s.rwE = 1'b1; s.wE = 5'd4;
    cyc(s); cyc(s);
    s.br = 1'b0;
    div_run(5);

    // Reset mid-BUSY, then a fresh full divide.
    s.rst = 1'b1; cyc(s);
    s.rst = 1'b0;
    div_run(DIV_CYCLES + 1);
    s = '0; cyc(s);

    // Randomised mix on a small register set to provoke collisions.
    for (int i = 0; i < 300; i++) begin
      s.rst  = ($urandom_range(0, 59) == 0);
      s.rsD  = 5'($urandom_range(0, 3)); s.rtD = 5'($urandom_range(0, 3));
      s.rsE  = 5'($urandom_range(0, 3)); s.rtE = 5'($urandom_range(0, 3));
      s.wE   = 5'($urandom_range(0, 3)); s.wM  = 5'($urandom_range(0, 3));
      s.wW   = 5'($urandom_range(0, 3));
      s.rwE  = 1'($urandom_range(0, 1)); s.rwM = 1'($urandom_range(0, 1));
      s.rwW  = 1'($urandom_range(0, 1));
      s.mtrE = ($urandom_range(0, 3) == 0); s.mtrM = ($urandom_range(0, 3) == 0);
      s.br   = ($urandom_range(0, 3) == 0); s.jr   = ($urandom_range(0, 7) == 0);
      s.ds   = ($urandom_range(0, 7) == 0);
      cyc(s);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
